// File: rtl/dma_req_issuer.sv
// dma_req_issuer: splits one (vaddr, len) transfer command into DMA requests
// that never cross a 2^PAGE_BITS page and never exceed MAX_XFER bytes.
// Commands whose end address lies beyond 2^VADDR_BITS are rejected with err.
//
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   s_cmd_valid/ready       command handshake (ready only while idle)
//   s_cmd_vaddr, s_cmd_len  command start address and byte length
//   m_req_valid/ready       request handshake towards the gateway
//   m_req_vaddr, m_req_len  request address and length (registered)
//   done, err               one-cycle completion pulse; err qualified by done
//   chunk_cnt               requests issued for the current/last command
module dma_req_issuer #(
   parameter int unsigned VADDR_BITS = 48,
   parameter int unsigned LEN_BITS   = 28,
   parameter int unsigned PAGE_BITS  = 12,
   parameter int unsigned MAX_XFER   = 4096,
   parameter int unsigned CNT_BITS   = 16
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  s_cmd_valid,
   output logic                  s_cmd_ready,
   input  logic [VADDR_BITS-1:0] s_cmd_vaddr,
   input  logic [LEN_BITS-1:0]   s_cmd_len,
   output logic                  m_req_valid,
   input  logic                  m_req_ready,
   output logic [VADDR_BITS-1:0] m_req_vaddr,
   output logic [LEN_BITS-1:0]   m_req_len,
   output logic                  done,
   output logic                  err,
   output logic [CNT_BITS-1:0]   chunk_cnt
);

   localparam int unsigned LW = LEN_BITS + 1;
   localparam int unsigned AW = VADDR_BITS + 1;
   localparam logic [LW-1:0] PAGE_SZ  = LW'(1) << PAGE_BITS;
   localparam logic [LW-1:0] MAX_SZ   = LW'(MAX_XFER);
   localparam logic [AW-1:0] ADDR_TOP = AW'(1) << VADDR_BITS;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t                state_q;
   logic [VADDR_BITS-1:0] vaddr_q;
   logic [LEN_BITS-1:0]   rem_q;
   logic [LEN_BITS-1:0]   chunk_q;
   logic [CNT_BITS-1:0]   cnt_q;
   logic                  done_q;
   logic                  err_q;

   // Largest legal request starting at page offset off with rem bytes left.
   function automatic logic [LEN_BITS-1:0] chunk_f(input logic [PAGE_BITS-1:0] off,
                                                   input logic [LEN_BITS-1:0]  rem);
      logic [LW-1:0] page_left;
      logic [LW-1:0] lim;
      logic [LEN_BITS-1:0] res;
      page_left = PAGE_SZ - LW'(off);
      lim       = (MAX_SZ < page_left) ? MAX_SZ : page_left;
      if (LW'(rem) <= lim) res = rem;
      else                 res = lim[LEN_BITS-1:0];
      return res;
   endfunction

   // Overflow pre-check at one extra bit so the end address cannot wrap.
   logic [AW-1:0] cmd_end;
   logic          cmd_ovf;
   assign cmd_end = {1'b0, s_cmd_vaddr} + AW'(s_cmd_len);
   assign cmd_ovf = cmd_end > ADDR_TOP;

   // Position after the current request is accepted.
   logic [VADDR_BITS-1:0] vaddr_adv;
   logic [LEN_BITS-1:0]   rem_adv;
   logic                  last_chunk;
   assign vaddr_adv  = vaddr_q + VADDR_BITS'(chunk_q);
   assign rem_adv    = rem_q - chunk_q;
   assign last_chunk = (rem_q == chunk_q);

   // Issue FSM; the next chunk is precomputed so request outputs are registers.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= IDLE;
         vaddr_q <= '0;
         rem_q   <= '0;
         chunk_q <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (state_q == IDLE) begin
            if (s_cmd_valid) begin
               vaddr_q <= s_cmd_vaddr;
               rem_q   <= s_cmd_len;
               chunk_q <= chunk_f(s_cmd_vaddr[PAGE_BITS-1:0], s_cmd_len);
               cnt_q   <= '0;
               if (s_cmd_len == '0) begin
                  done_q <= 1'b1;
                  err_q  <= 1'b0;
               end else if (cmd_ovf) begin
                  done_q <= 1'b1;
                  err_q  <= 1'b1;
               end else begin
                  state_q <= ISSUE;
               end
            end
         end else if (m_req_ready) begin
            vaddr_q <= vaddr_adv;
            rem_q   <= rem_adv;
            chunk_q <= chunk_f(vaddr_adv[PAGE_BITS-1:0], rem_adv);
            if (cnt_q != '1) cnt_q <= cnt_q + CNT_BITS'(1);
            if (last_chunk) begin
               state_q <= IDLE;
               done_q  <= 1'b1;
               err_q   <= 1'b0;
            end
         end
      end
   end

   assign s_cmd_ready = (state_q == IDLE);
   assign m_req_valid = (state_q == ISSUE);
   assign m_req_vaddr = vaddr_q;
   assign m_req_len   = chunk_q;
   assign done        = done_q;
   assign err         = err_q;
   assign chunk_cnt   = cnt_q;

endmodule

// File: tb/tb_dma_req_issuer.sv
// Bench for dma_req_issuer: two instances (MAX_XFER 4096 and 1024) share the
// stimulus; a transaction-level model predicts every output each cycle.
module tb_dma_req_issuer;

   logic        aclk = 1'b0;
   logic        areset;
   logic        s_cmd_valid;
   logic [47:0] s_cmd_vaddr;
   logic [27:0] s_cmd_len;
   logic        m_req_ready;

   logic        cmd_rdy [2];
   logic        req_v   [2];
   logic [47:0] req_va  [2];
   logic [27:0] req_len [2];
   logic        done_o  [2];
   logic        err_o   [2];
   logic [15:0] cnt_o   [2];

   int checks = 0;
   int errors = 0;

   always #5 aclk = ~aclk;

   dma_req_issuer u_dut0 (
      .aclk(aclk), .areset(areset),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(cmd_rdy[0]),
      .s_cmd_vaddr(s_cmd_vaddr), .s_cmd_len(s_cmd_len),
      .m_req_valid(req_v[0]), .m_req_ready(m_req_ready),
      .m_req_vaddr(req_va[0]), .m_req_len(req_len[0]),
      .done(done_o[0]), .err(err_o[0]), .chunk_cnt(cnt_o[0]));

   dma_req_issuer #(.MAX_XFER(1024)) u_dut1 (
      .aclk(aclk), .areset(areset),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(cmd_rdy[1]),
      .s_cmd_vaddr(s_cmd_vaddr), .s_cmd_len(s_cmd_len),
      .m_req_valid(req_v[1]), .m_req_ready(m_req_ready),
      .m_req_vaddr(req_va[1]), .m_req_len(req_len[1]),
      .done(done_o[1]), .err(err_o[1]), .chunk_cnt(cnt_o[1]));

   // Model state: one outstanding command per instance.
   bit              m_busy [2];
   longint unsigned m_va   [2];
   longint unsigned m_rem  [2];
   bit              m_done [2];
   bit              m_err  [2];
   longint unsigned m_cnt  [2];
   longint unsigned log_va  [2][16];
   longint unsigned log_len [2][16];
   int              log_n   [2];

   task automatic chk(input string name, input int k,
                      input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, k, act, exp, $time);
      end
   endtask

   function automatic longint unsigned max_of(input int k);
      return (k == 0) ? 64'd4096 : 64'd1024;
   endfunction

   function automatic longint unsigned exp_chunk(input int k);
      longint unsigned c;
      longint unsigned page_left;
      c = m_rem[k];
      if (c > max_of(k)) c = max_of(k);
      page_left = 64'd4096 - (m_va[k] % 64'd4096);
      if (c > page_left) c = page_left;
      return c;
   endfunction

   // Per-cycle compare against the model, then advance the model on the
   // inputs that the next rising edge will sample.
   always @(negedge aclk) begin
      for (int k = 0; k < 2; k++) begin
         if (areset) begin
            chk("rst_valid", k, req_v[k], 0);
            chk("rst_vaddr", k, req_va[k], 0);
            chk("rst_len",   k, req_len[k], 0);
            chk("rst_done",  k, done_o[k], 0);
            chk("rst_err",   k, err_o[k], 0);
            chk("rst_cnt",   k, cnt_o[k], 0);
            m_busy[k] = 0; m_done[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
         end else begin
            longint unsigned c;
            bit done_n;
            chk("cmd_ready", k, cmd_rdy[k], !m_busy[k]);
            chk("req_valid", k, req_v[k], m_busy[k]);
            if (m_busy[k]) begin
               chk("req_vaddr", k, req_va[k], m_va[k]);
               chk("req_len",   k, req_len[k], exp_chunk(k));
            end
            chk("done",      k, done_o[k], m_done[k]);
            chk("err",       k, err_o[k], m_err[k]);
            chk("chunk_cnt", k, cnt_o[k], m_cnt[k]);

            done_n = 0;
            if (!m_busy[k] && s_cmd_valid) begin
               m_cnt[k] = 0;
               log_n[k] = 0;
               if (s_cmd_len == 0) begin
                  done_n = 1; m_err[k] = 0;
               end else if (longint'(s_cmd_vaddr) + longint'(s_cmd_len) > (64'd1 << 48)) begin
                  done_n = 1; m_err[k] = 1;
               end else begin
                  m_busy[k] = 1; m_va[k] = s_cmd_vaddr; m_rem[k] = s_cmd_len;
               end
            end else if (m_busy[k] && m_req_ready) begin
               c = exp_chunk(k);
               if (log_n[k] < 16) begin
                  log_va[k][log_n[k]]  = m_va[k];
                  log_len[k][log_n[k]] = c;
               end
               log_n[k]++;
               m_va[k]  += c;
               m_rem[k] -= c;
               if (m_cnt[k] != 64'hFFFF) m_cnt[k]++;
               if (m_rem[k] == 0) begin
                  m_busy[k] = 0; done_n = 1; m_err[k] = 0;
               end
            end
            m_done[k] = done_n;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!(cmd_rdy[0] && cmd_rdy[1]) && n < 500) begin
         @(posedge aclk); #1;
         n++;
      end
      chk("idle_timeout", 0, (n >= 500) ? 1 : 0, 0);
   endtask

   task automatic send_cmd(input logic [47:0] va, input logic [27:0] len);
      wait_idle();
      s_cmd_valid = 1'b1;
      s_cmd_vaddr = va;
      s_cmd_len   = len;
      @(posedge aclk); #1;
      s_cmd_valid = 1'b0;
   endtask

   task automatic pin(input int k, input int idx, input longint unsigned va, input longint unsigned len);
      chk("log_vaddr", k, log_va[k][idx], va);
      chk("log_len",   k, log_len[k][idx], len);
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish, expected finish by 300000");
      $fatal(1, "timeout");
   end

   initial begin
      areset = 1'b1; s_cmd_valid = 1'b0; s_cmd_vaddr = '0; s_cmd_len = '0; m_req_ready = 1'b1;
      repeat (2) @(posedge aclk); #1;
      areset = 1'b0;
      @(posedge aclk); #1;
      chk("ready_after_reset", 0, cmd_rdy[0], 1);

      // Aligned multi-page: three requests back to back, done on the 4th cycle.
      send_cmd(48'h1000, 28'h3000);
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         chk("aligned_valid", 0, req_v[0], 1);
      end
      @(negedge aclk);
      chk("aligned_done", 0, done_o[0], 1);
      chk("aligned_err",  0, err_o[0], 0);
      chk("aligned_cnt",  0, cnt_o[0], 3);
      wait_idle();
      chk("aligned_n", 0, log_n[0], 3);
      pin(0, 0, 48'h1000, 28'h1000);
      pin(0, 1, 48'h2000, 28'h1000);
      pin(0, 2, 48'h3000, 28'h1000);
      chk("aligned_n", 1, log_n[1], 12);

      // Unaligned page crossing.
      send_cmd(48'h0F00, 28'h300);
      wait_idle();
      pin(0, 0, 48'h0F00, 28'h100);
      pin(0, 1, 48'h1000, 28'h200);
      chk("unaligned_cnt", 0, cnt_o[0], 2);
      chk("unaligned_cnt", 1, cnt_o[1], 2);

      // Size cap at 1024 on the second instance.
      send_cmd(48'h2200, 28'h900);
      wait_idle();
      pin(1, 0, 48'h2200, 28'h400);
      pin(1, 1, 48'h2600, 28'h400);
      pin(1, 2, 48'h2A00, 28'h100);
      pin(0, 0, 48'h2200, 28'h900);

      // Zero length: no request, done without error.
      send_cmd(48'h1234, 28'h0);
      @(negedge aclk);
      chk("zero_done",  0, done_o[0], 1);
      chk("zero_err",   0, err_o[0], 0);
      chk("zero_valid", 1, req_v[1], 0);

      // Overflow reject, then a command accepted in the done cycle that ends at 2^48.
      send_cmd(48'hFFFF_FFFF_F000, 28'h2000);
      send_cmd(48'hFFFF_FFFF_F000, 28'h1000);
      @(negedge aclk);
      chk("top_valid",    0, req_v[0], 1);
      chk("top_vaddr",    0, req_va[0], 48'hFFFF_FFFF_F000);
      chk("top_len",      0, req_len[0], 28'h1000);
      chk("ovf_err_held", 0, err_o[0], 1);
      wait_idle();
      chk("top_err", 0, err_o[0], 0);
      chk("top_cnt", 0, cnt_o[0], 1);
      chk("top_cnt", 1, cnt_o[1], 4);
      pin(1, 3, 48'hFFFF_FFFF_FC00, 28'h400);

      // Back-pressure after the first handshake.
      send_cmd(48'h1000, 28'h3000);
      @(posedge aclk); #1;
      m_req_ready = 1'b0;
      repeat (5) begin
         @(negedge aclk);
         chk("bp_valid", 0, req_v[0], 1);
         chk("bp_vaddr", 0, req_va[0], 48'h2000);
         chk("bp_len",   0, req_len[0], 28'h1000);
         chk("bp_ready", 0, cmd_rdy[0], 0);
      end
      @(posedge aclk); #1;
      m_req_ready = 1'b1;
      wait_idle();
      chk("bp_cnt", 0, cnt_o[0], 3);
      pin(0, 2, 48'h3000, 28'h1000);

      // Reset after the first of three handshakes.
      send_cmd(48'h1000, 28'h3000);
      @(posedge aclk); #1;
      areset = 1'b1;
      #1;
      chk("midrst_valid", 0, req_v[0], 0);
      chk("midrst_vaddr", 0, req_va[0], 0);
      chk("midrst_len",   0, req_len[0], 0);
      chk("midrst_cnt",   0, cnt_o[0], 0);
      @(posedge aclk); #1;
      areset = 1'b0;
      repeat (3) begin
         @(negedge aclk);
         chk("midrst_no_done", 0, done_o[0], 0);
      end
      send_cmd(48'h5000, 28'h2000);
      wait_idle();
      chk("after_rst_n", 0, log_n[0], 2);
      pin(0, 0, 48'h5000, 28'h1000);
      pin(0, 1, 48'h6000, 28'h1000);

      repeat (3) @(posedge aclk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
